// File: rtl/committed_store_drain.sv
// Committed-store buffer: holds retired stores until they are written to the
// dcache one at a time, oldest first, and lets loads forward from pending data.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no dcache write outstanding; dmem_* driven to 0
// S_WAIT | head entry presented to dcache, held until dmem_resp
module committed_store_drain #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_addr,
    input  logic [31:0]              enq_wdata,
    input  logic [3:0]               enq_wmask,
    output logic                     enq_ready,
    output logic [31:0]              dmem_addr,
    output logic [31:0]              dmem_wdata,
    output logic [3:0]               dmem_wmask,
    output logic [3:0]               dmem_rmask,
    input  logic                     dmem_resp,
    input  logic [31:0]              lookup_addr,
    output logic [3:0]               fwd_mask,
    output logic [31:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [29:0]   r_addr  [DEPTH];
    logic [31:0]   r_wdata [DEPTH];
    logic [3:0]    r_wmask [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          w_enq;
    logic          w_pop;
    logic [AW-1:0] w_slot;
    logic          w_unused_bits;

    // Word-offset bits of addresses are meaningless here.
    assign w_unused_bits = ^{enq_addr[1:0], lookup_addr[1:0]};

    assign enq_ready  = (r_count != (AW+1)'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign dmem_rmask = 4'b0000;

    // A zero-mask store carries no data, so it is never allocated.
    assign w_enq = enq_valid && enq_ready && (enq_wmask != 4'b0000);
    assign w_pop = (r_state == S_WAIT) && dmem_resp;

    // Entry payload; occupancy (head/count) decides validity, so no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail]  <= enq_addr[31:2];
            r_wdata[r_tail] <= enq_wdata;
            r_wmask[r_tail] <= enq_wmask;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Drain FSM next state and dcache request outputs.
    always_comb begin
        w_state_nxt = r_state;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        dmem_wmask  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                dmem_addr  = {r_addr[r_head], 2'b00};
                dmem_wdata = r_wdata[r_head];
                dmem_wmask = r_wmask[r_head];
                if (dmem_resp) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Forwarding: walk oldest to youngest so younger matches overwrite lanes.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        w_slot   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = r_head + AW'(i);
            if (((AW+1)'(i) < r_count) && (r_addr[w_slot] == lookup_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_wmask[w_slot][b]) begin
                        fwd_mask[b]        = 1'b1;
                        fwd_data[8*b +: 8] = r_wdata[w_slot][8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_committed_store_drain.sv
// Bench for committed_store_drain: directed scenarios plus a random phase,
// all compared against a queue-based model of the store buffer.
module tb_committed_store_drain;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_addr = '0;
    logic [31:0] enq_wdata = '0;
    logic [3:0]  enq_wmask = '0;
    logic        enq_ready;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [3:0]  dmem_rmask;
    logic        dmem_resp = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic [3:0]  count;
    logic        empty;

    committed_store_drain #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_wdata(enq_wdata),
        .enq_wmask(enq_wmask), .enq_ready(enq_ready),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_rmask(dmem_rmask), .dmem_resp(dmem_resp),
        .lookup_addr(lookup_addr), .fwd_mask(fwd_mask), .fwd_data(fwd_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    ent_t q[$];
    bit   m_busy = 1'b0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model before the coming edge.
    task automatic check_all();
        logic [3:0]  em;
        logic [31:0] ed;
        em = '0;
        ed = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].addr[31:2] == lookup_addr[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (q[i].mask[b]) begin
                        em[b]        = 1'b1;
                        ed[8*b +: 8] = q[i].data[8*b +: 8];
                    end
                end
            end
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("enq_ready", 32'(enq_ready), 32'(q.size() != DEPTH));
        chk("dmem_rmask", 32'(dmem_rmask), 32'h0);
        chk("dmem_addr", dmem_addr, m_busy ? q[0].addr : 32'h0);
        chk("dmem_wdata", dmem_wdata, m_busy ? q[0].data : 32'h0);
        chk("dmem_wmask", 32'(dmem_wmask), m_busy ? 32'(q[0].mask) : 32'h0);
        chk("fwd_mask", 32'(fwd_mask), 32'(em));
        chk("fwd_data", fwd_data, ed);
    endtask

    // Model of one clock edge: a request is outstanding from the edge after
    // the buffer is seen non-empty until the edge carrying the response.
    task automatic model_edge(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic r, input logic rs);
        bit   had_any;
        bit   take;
        ent_t e;
        if (rs) begin
            q.delete();
            m_busy = 1'b0;
            return;
        end
        had_any = (q.size() > 0);
        take    = v && (q.size() < DEPTH) && (m != 4'b0000);
        if (m_busy) begin
            if (r) begin
                void'(q.pop_front());
                m_busy = 1'b0;
            end
        end else if (had_any) begin
            m_busy = 1'b1;
        end
        if (take) begin
            e.addr = {a[31:2], 2'b00};
            e.data = d;
            e.mask = m;
            q.push_back(e);
        end
    endtask

    // One clock: drive at negedge, check, advance model at posedge, settle 1.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic r, input logic rs,
                         input logic [31:0] la);
        @(negedge clk);
        enq_valid   = v;
        enq_addr    = a;
        enq_wdata   = d;
        enq_wmask   = m;
        dmem_resp   = r;
        rst         = rs;
        lookup_addr = la;
        #1;
        if (chk_en) check_all();
        @(posedge clk);
        model_edge(v, a, d, m, r, rs);
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] la);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, la);
    endtask

    task automatic do_reset();
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        int          sent;
        int          lat;
        logic [31:0] ra;

        do_reset();
        do_reset();
        chk_en = 1'b1;

        // Reset values (checked inside the idle cycle against an empty model).
        idle(1, 32'h0);

        // Single store with 3 cycles of dcache latency.
        cycle(1'b1, 32'h1000_0006, 32'h00AB_0000, 4'b0100, 1'b0, 1'b0, 32'h1000_0004);
        idle(1, 32'h1000_0004);
        chk("single_count", 32'(count), 32'd1);
        idle(2, 32'h1000_0004);
        chk("single_req_addr", dmem_addr, 32'h1000_0004);
        chk("single_req_mask", 32'(dmem_wmask), 32'h4);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h1000_0004);
        chk("single_after_count", 32'(count), 32'd0);
        chk("single_after_empty", 32'(empty), 32'd1);
        chk("single_after_mask", 32'(dmem_wmask), 32'h0);
        idle(2, 32'h0);

        // Fill with dcache stalled, ninth store refused, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h8);
        chk("fill_ready", 32'(enq_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd8);
        cycle(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h40);
        chk("fill_ninth_count", 32'(count), 32'd8);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h40);
        chk("fill_ready_after_pop", 32'(enq_ready), 32'd1);
        for (int k = 0; k < 40 && q.size() > 0; k++)
            cycle(1'b0, 32'h0, 32'h0, 4'h0, m_busy, 1'b0, 32'h1C);
        chk("fill_drained", 32'(count), 32'd0);

        // Youngest-wins forwarding.
        do_reset();
        cycle(1'b1, 32'h200, 32'h1122_3344, 4'b1111, 1'b0, 1'b0, 32'h202);
        cycle(1'b1, 32'h200, 32'hAA00_0000, 4'b1000, 1'b0, 1'b0, 32'h202);
        cycle(1'b1, 32'h204, 32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b0, 32'h202);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h202);
        chk("fwd_hit_mask", 32'(fwd_mask), 32'hF);
        chk("fwd_hit_data", fwd_data, 32'hAA22_3344);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h300);
        chk("fwd_miss_mask", 32'(fwd_mask), 32'h0);
        chk("fwd_miss_data", fwd_data, 32'h0);

        // Enqueue on every response cycle: count constant, pointers wrap.
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h500 + 32'(i * 4), $urandom, 4'(1 + $urandom_range(0, 14)), 1'b0, 1'b0, 32'h500);
        sent = 0;
        lat  = 0;
        for (int k = 0; k < 300 && sent < 20; k++) begin
            ra = 32'h500 + 32'($urandom_range(0, 3) * 4);
            if (m_busy && lat >= 2) begin
                cycle(1'b1, 32'h500 + 32'((sent % 5) * 4), $urandom,
                      4'(1 + $urandom_range(0, 14)), 1'b1, 1'b0, ra);
                sent++;
                lat = 0;
            end else begin
                if (m_busy) lat++;
                cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, ra);
            end
            chk("simul_count", 32'(count), 32'd3);
        end
        chk("simul_sent", 32'(sent), 32'd20);

        // Zero-mask store is dropped.
        do_reset();
        cycle(1'b1, 32'h700, 32'h1234_5678, 4'b0000, 1'b0, 1'b0, 32'h700);
        chk("zmask_count", 32'(count), 32'd0);
        idle(3, 32'h700);
        chk("zmask_no_req", 32'(dmem_wmask), 32'h0);

        // Reset while a request is outstanding with 3 entries queued.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h800 + 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 32'h800);
        chk("midrst_pre_mask", 32'(dmem_wmask), 32'hF);
        do_reset();
        chk("midrst_mask", 32'(dmem_wmask), 32'h0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h800);
        idle(1, 32'h800);
        chk("midrst_resp_ignored", 32'(count), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 99) < 55),
                  32'h100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
                  $urandom,
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 199) == 0),
                  32'h100 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
